// File: rtl/mnist_pkg.sv
// Shared constants and types for the serial pixel receiver and its frame buffer.
// The receiver is parameterised; the defaults below describe a 28x28 binarised image.
package mnist_pkg;

   localparam int IMG_W   = 28;
   localparam int IMG_H   = 28;
   localparam int IMG_PIX = IMG_W * IMG_H;
   localparam int ROW_AW  = 5;
   localparam int PIX_CW  = 10;

   typedef logic [IMG_W-1:0] row_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } rx_state_t;

endpackage

// File: rtl/mnist_frame_buf.sv
// Bit-addressable frame storage: single-bit writes, one registered row read per cycle.
// Rows at or beyond IMG_H read back as zero.
module mnist_frame_buf #(
   parameter int IMG_W  = mnist_pkg::IMG_W,
   parameter int IMG_H  = mnist_pkg::IMG_H,
   parameter int ROW_AW = mnist_pkg::ROW_AW,
   parameter int COL_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ROW_AW-1:0] wr_row,
   input  logic [COL_W-1:0]  wr_col,
   input  logic              wr_bit,
   input  logic              rd_en,
   input  logic [ROW_AW-1:0] rd_row,
   output logic [IMG_W-1:0]  rd_data,
   output logic              rd_valid
);

   logic [IMG_W-1:0] rows_reg [IMG_H];
   logic [IMG_H-1:0] row_we;
   logic             rd_in_range;

   genvar gi;
   generate
      for (gi = 0; gi < IMG_H; gi++) begin : g_row_we
         assign row_we[gi] = we && (wr_row == ROW_AW'(gi));
      end
   endgenerate

   assign rd_in_range = ({1'b0, rd_row} < (ROW_AW+1)'(IMG_H));

   // The whole array clears on reset, so it is built from flops rather than block RAM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < IMG_H; r++) begin
            rows_reg[r] <= '0;
         end
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int r = 0; r < IMG_H; r++) begin
            if (row_we[r]) begin
               rows_reg[r][wr_col] <= wr_bit;
            end
         end
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_in_range ? rows_reg[rd_row] : '0;
         end
      end
   end

endmodule

// File: rtl/mnist_bit_frame_rx.sv
// Deserialises a row-major 1-bit pixel stream into a frame buffer and holds the
// completed frame for row-wise reads until the consumer releases it.
module mnist_bit_frame_rx #(
   parameter int IMG_W  = mnist_pkg::IMG_W,
   parameter int IMG_H  = mnist_pkg::IMG_H,
   parameter int ROW_AW = mnist_pkg::ROW_AW,
   parameter int PIX_CW = mnist_pkg::PIX_CW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_in,
   input  logic              valid_in,
   output logic              frame_ready,
   input  logic              frame_release,
   input  logic              rd_en,
   input  logic [ROW_AW-1:0] rd_row,
   output logic [IMG_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              drop_err,
   output logic [7:0]        frame_cnt
);
   import mnist_pkg::*;

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int PIX_N = IMG_W * IMG_H;

   rx_state_t         state_reg, state_next;
   logic [PIX_CW-1:0] pix_reg, pix_next;
   logic [COL_W-1:0]  col_reg, col_next;
   logic [ROW_AW-1:0] row_reg, row_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic              drop_reg, drop_next;
   logic              wr_en;
   logic              rd_req;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= FILL;
         pix_reg   <= '0;
         col_reg   <= '0;
         row_reg   <= '0;
         cnt_reg   <= '0;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pix_reg   <= pix_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
         cnt_reg   <= cnt_next;
         drop_reg  <= drop_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pix_next   = pix_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      cnt_next   = cnt_reg;
      drop_next  = 1'b0;
      wr_en      = 1'b0;
      case (state_reg)
         FILL: begin
            if (valid_in) begin
               wr_en = 1'b1;
               if (pix_reg == PIX_CW'(PIX_N-1)) begin
                  state_next = FULL;
                  pix_next   = '0;
                  col_next   = '0;
                  row_next   = '0;
                  cnt_next   = cnt_reg + 8'd1;
               end else begin
                  pix_next = pix_reg + 1'b1;
                  if (col_reg == COL_W'(IMG_W-1)) begin
                     col_next = '0;
                     row_next = row_reg + 1'b1;
                  end else begin
                     col_next = col_reg + 1'b1;
                  end
               end
            end
         end
         FULL: begin
            // Counters sit at zero here, so a pixel arriving with the release lands at row 0, col 0.
            if (frame_release) begin
               state_next = FILL;
               if (valid_in) begin
                  wr_en    = 1'b1;
                  pix_next = PIX_CW'(1);
                  col_next = COL_W'(1);
               end
            end else if (valid_in) begin
               drop_next = 1'b1;
            end
         end
         default: state_next = FILL;
      endcase
   end

   assign rd_req      = rd_en && (state_reg == FULL);
   assign frame_ready = (state_reg == FULL);
   assign drop_err    = drop_reg;
   assign frame_cnt   = cnt_reg;

   mnist_frame_buf #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ROW_AW (ROW_AW),
      .COL_W  (COL_W)
   ) u_frame_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_en),
      .wr_row   (row_reg),
      .wr_col   (col_reg),
      .wr_bit   (data_in),
      .rd_en    (rd_req),
      .rd_row   (rd_row),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

endmodule

// File: tb/tb_mnist_bit_frame_rx.sv
// Randomised bench for mnist_bit_frame_rx against a pixel-list reference model;
// a second, small instance exercises the frame counter wrap in few cycles.
module tb_mnist_bit_frame_rx;

   localparam int W = 28;
   localparam int H = 28;
   localparam int NPIX = W * H;

   logic        clk;
   logic        rst_n;
   logic        data_in;
   logic        valid_in;
   logic        frame_ready;
   logic        frame_release;
   logic        rd_en;
   logic [4:0]  rd_row;
   logic [27:0] rd_data;
   logic        rd_valid;
   logic        drop_err;
   logic [7:0]  frame_cnt;

   logic        s_rst_n;
   logic        s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_release;
   logic        s_rd_en;
   logic [0:0]  s_rd_row;
   logic [3:0]  s_rd_data;
   logic        s_rd_valid;
   logic        s_drop;
   logic [7:0]  s_cnt;

   int n_checks;
   int n_errors;

   // Reference model: the list of accepted pixels of the current image.
   bit          img [NPIX];
   bit          pat [NPIX];
   int          npix;
   bit          held;
   int          fcnt;
   logic [27:0] last_rd;

   mnist_bit_frame_rx dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .frame_ready   (frame_ready),
      .frame_release (frame_release),
      .rd_en         (rd_en),
      .rd_row        (rd_row),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .drop_err      (drop_err),
      .frame_cnt     (frame_cnt)
   );

   mnist_bit_frame_rx #(
      .IMG_W  (4),
      .IMG_H  (2),
      .ROW_AW (1),
      .PIX_CW (3)
   ) dut_small (
      .clk           (clk),
      .rst_n         (s_rst_n),
      .data_in       (s_data),
      .valid_in      (s_valid),
      .frame_ready   (s_ready),
      .frame_release (s_release),
      .rd_en         (s_rd_en),
      .rd_row        (s_rd_row),
      .rd_data       (s_rd_data),
      .rd_valid      (s_rd_valid),
      .drop_err      (s_drop),
      .frame_cnt     (s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] row_word(input int r);
      logic [27:0] w;
      w = '0;
      if (r < H) begin
         for (int c = 0; c < W; c++) begin
            w[c] = img[r*W + c];
         end
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NPIX; i++) img[i] = 1'b0;
      npix    = 0;
      held    = 1'b0;
      fcnt    = 0;
      last_rd = '0;
   endtask

   task automatic reset_dut();
      rst_n         = 1'b0;
      valid_in      = 1'b0;
      data_in       = 1'b0;
      frame_release = 1'b0;
      rd_en         = 1'b0;
      rd_row        = '0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      check("rst_ready", {31'd0, frame_ready}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_data", {4'd0, rd_data}, 32'd0);
      check("rst_drop", {31'd0, drop_err}, 32'd0);
      check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
   endtask

   // One clock cycle: drive inputs, advance the model, then compare every output.
   task automatic cyc(input bit v, input bit d, input bit rel, input bit re, input int row);
      bit          exp_rv;
      bit          exp_drop;
      logic [27:0] exp_rd;
      logic [31:0] row_v;
      row_v         = row;
      valid_in      = v;
      data_in       = d;
      frame_release = rel;
      rd_en         = re;
      rd_row        = row_v[4:0];
      exp_rv   = re && held;
      exp_rd   = exp_rv ? row_word(row) : last_rd;
      last_rd  = exp_rd;
      exp_drop = held && v && !rel;
      if (held && rel) held = 1'b0;
      if (v && !held) begin
         img[npix] = d;
         npix++;
         if (npix == NPIX) begin
            held = 1'b1;
            npix = 0;
            fcnt = (fcnt + 1) % 256;
         end
      end
      @(posedge clk);
      #1;
      check("ready", {31'd0, frame_ready}, {31'd0, held});
      check("drop", {31'd0, drop_err}, {31'd0, exp_drop});
      check("cnt", {24'd0, frame_cnt}, fcnt);
      check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
      check("rd_data", {4'd0, rd_data}, {4'd0, exp_rd});
   endtask

   task automatic send_frame(input int start, input int gap);
      int i;
      int k;
      bit re;
      bit rel;
      int row;
      i = start;
      k = 0;
      while (i < NPIX) begin
         re  = ($urandom_range(0, 3) == 0);
         rel = ($urandom_range(0, 7) == 0);
         row = $urandom_range(0, 31);
         if (gap > 0 && (k % gap) == gap - 1) begin
            cyc(1'b0, 1'b0, rel, re, row);
         end else begin
            cyc(1'b1, pat[i], rel, re, row);
            i++;
         end
         k++;
      end
   endtask

   task automatic read_all();
      for (int r = 0; r < H; r++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1, r);
      end
   endtask

   initial begin
      int drops;
      n_checks  = 0;
      n_errors  = 0;
      s_rst_n   = 1'b0;
      s_data    = 1'b0;
      s_valid   = 1'b0;
      s_release = 1'b0;
      s_rd_en   = 1'b0;
      s_rd_row  = '0;
      reset_dut();
      s_rst_n = 1'b1;

      // Alternating image, no gaps.
      for (int i = 0; i < NPIX; i++) pat[i] = i[0];
      send_frame(0, 0);
      check("ready_after_784", {31'd0, frame_ready}, 32'd1);
      check("cnt_first", {24'd0, frame_cnt}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
      check("row0_alt", {4'd0, rd_data}, 32'h0AAAAAAA);
      read_all();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 28);
      check("row28_data", {4'd0, rd_data}, 32'd0);
      check("row28_valid", {31'd0, rd_valid}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 31);
      $display("frame 1 alternating done, cnt=%0d", frame_cnt);

      // Same image with a gap every third cycle.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("released", {31'd0, frame_ready}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
      check("rd_not_ready", {31'd0, rd_valid}, 32'd0);
      send_frame(0, 3);
      read_all();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 5);
      check("row5_gapped", {4'd0, rd_data}, 32'h0AAAAAAA);
      $display("frame 2 gapped done, cnt=%0d", frame_cnt);

      // Pixels arriving while the frame is held are dropped.
      drops = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
         if (drop_err) drops++;
      end
      check("drop_pulses", drops, 32'd5);
      check("cnt_after_drop", {24'd0, frame_cnt}, 32'd2);
      read_all();
      $display("drop phase done, drops=%0d", drops);

      // Release with a pixel in the same cycle, plus a read of the frozen frame.
      pat[0] = 1'b1;
      for (int i = 1; i < NPIX; i++) pat[i] = 1'b0;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 3);
      check("rd_on_release", {4'd0, rd_data}, 32'h0AAAAAAA);
      check("no_drop_release", {31'd0, drop_err}, 32'd0);
      send_frame(1, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
      check("row0_single", {4'd0, rd_data}, 32'h00000001);
      read_all();
      check("cnt_third", {24'd0, frame_cnt}, 32'd3);
      $display("frame 3 release-with-pixel done, cnt=%0d", frame_cnt);

      // Reset part-way through a fill.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 400; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
      reset_dut();
      for (int i = 0; i < NPIX; i++) pat[i] = 1'b1;
      send_frame(0, 0);
      check("ready_after_reset", {31'd0, frame_ready}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 27);
      check("row27_ones", {4'd0, rd_data}, 32'h0FFFFFFF);
      read_all();
      check("cnt_after_reset", {24'd0, frame_cnt}, 32'd1);
      $display("reset-mid-fill phase done, cnt=%0d", frame_cnt);

      // Random images, random gaps, random reads.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NPIX; i++) pat[i] = 1'($urandom_range(0, 1));
         cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 31));
         send_frame(0, $urandom_range(0, 4));
         for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'b0,
                1'($urandom_range(0, 1)), $urandom_range(0, 31));
         end
         $display("random frame %0d done, cnt=%0d", f, frame_cnt);
      end

      // Frame counter wrap on the small instance.
      for (int f = 0; f < 256; f++) begin
         for (int p = 0; p < 8; p++) begin
            s_valid = 1'b1;
            s_data  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         s_valid = 1'b0;
         check("s_ready", {31'd0, s_ready}, 32'd1);
         check("s_cnt", {24'd0, s_cnt}, (f + 1) % 256);
         s_release = 1'b1;
         @(posedge clk);
         #1;
         s_release = 1'b0;
         check("s_released", {31'd0, s_ready}, 32'd0);
      end
      check("s_cnt_wrap", {24'd0, s_cnt}, 32'd0);
      $display("small instance wrap done, cnt=%0d", s_cnt);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
